// File: rtl/uart_rx_if.sv
// Receive-side signal bundle for the lab UART receiver.
// The receiver uses the slave view; the line driver and byte consumer use the master view.
interface uart_rx_if;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rxd,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rxd,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: LSB first, idle-high line, mid-bit sampling.
// state     | meaning
// IDLE      | line idle, waiting for a falling rxd_s
// START     | confirming the start bit at its mid-point
// DATA      | sampling eight data bits, one per bit period
// STOP      | sampling the stop bit; good frame or framing error
// WAIT_IDLE | after a framing error, waiting for the line to go high
module uart_rx #(
  parameter int CLKS_PER_BIT = 23
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             sync1;
  logic             rxd_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             err_q;
  logic             half_tick;
  logic             bit_tick;

  assign half_tick = (cnt == HALF_LAST);
  assign bit_tick  = (cnt == BIT_LAST);

  // Synchroniser resets to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= bus.rxd;
      rxd_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!rxd_s) state_next = START;
      START:     if (half_tick) state_next = rxd_s ? IDLE : DATA;
      DATA:      if (bit_tick && bit_idx == 3'd7) state_next = STOP;
      STOP:      if (bit_tick) state_next = rxd_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rxd_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (state_next != state || state == IDLE || state == WAIT_IDLE ||
          (state == DATA && bit_tick))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      if (state == START)
        bit_idx <= 3'd0;
      if (state == DATA && bit_tick) begin
        shreg   <= {rxd_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      // rx_data only moves on a good stop bit; a bad one just flags the error.
      if (state == STOP && bit_tick) begin
        if (rxd_s) begin
          data_q  <= shreg;
          valid_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.rx_data   = data_q;
    bus.rx_valid  = valid_q;
    bus.frame_err = err_q;
  end
endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: frames, glitches and framing errors are checked
// against a timing model that predicts each strobe from the frame start cycle.
module tb_uart_rx;
  localparam int C    = 23;
  localparam int HALF = C / 2;
  localparam int LAT  = 2 + HALF + 9 * C + 1;

  typedef struct {
    int         cyc;
    bit         err;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  ev_t        exp_q[$];
  int         valid_cycs[$];
  logic [7:0] model_data = 8'h00;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference: each queued event fires exactly at its predicted cycle; all other cycles are quiet.
  always @(negedge clk) begin
    if (rst_q) begin
      exp_q.delete();
      model_data = 8'h00;
      check("rst_valid", bus.rx_valid, 0);
      check("rst_err", bus.frame_err, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_data", bus.rx_data, 8'h00);
    end else begin
      automatic bit exp_v = 1'b0;
      automatic bit exp_e = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        automatic ev_t ev = exp_q.pop_front();
        if (ev.err) exp_e = 1'b1;
        else begin
          exp_v      = 1'b1;
          model_data = ev.data;
        end
      end
      if (bus.rx_valid) valid_cycs.push_back(cyc);
      check("rx_valid", bus.rx_valid, exp_v);
      check("frame_err", bus.frame_err, exp_e);
      check("rx_data", bus.rx_data, model_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic line_bit(input logic [7:0] d, input logic stop, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    return stop;
  endfunction

  task automatic gap(input int g);
    bus.rxd = 1'b1;
    repeat (g) begin
      tick();
      check("gap_busy", bus.busy, 0);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    int n;
    int rel;
    n = cyc;
    exp_q.push_back('{cyc: n + LAT, err: !stop, data: d});
    for (int k = 0; k < 10 * C; k++) begin
      bus.rxd = line_bit(d, stop, k / C);
      tick();
      rel = cyc - n;
      check("frame_busy", bus.busy, (rel >= 3 && (!stop || rel < LAT)) ? 1 : 0);
    end
  endtask

  task automatic hold_and_release(input int h);
    repeat (h) begin
      bus.rxd = 1'b0;
      tick();
      check("break_busy", bus.busy, 1);
    end
    bus.rxd = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("release_busy", bus.busy, (k < 3) ? 1 : 0);
    end
  endtask

  task automatic glitch(input int len);
    int n;
    n = cyc;
    for (int k = 1; k <= 20; k++) begin
      bus.rxd = (k <= len) ? 1'b0 : 1'b1;
      tick();
      check("glitch_busy", bus.busy, (k >= 3 && k <= 2 + HALF) ? 1 : 0);
    end
  endtask

  initial begin
    bus.rxd = 1'b1;
    rst     = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    tick();

    repeat (500) begin
      tick();
      check("idle_busy", bus.busy, 0);
    end

    send_frame(8'h31, 1'b1);
    gap(20);
    check("data_31", bus.rx_data, 8'h31);

    glitch(5);
    gap(10);

    send_frame(8'hA5, 1'b0);
    hold_and_release(100);
    check("hold_data", bus.rx_data, 8'h31);
    gap(10);

    valid_cycs.delete();
    send_frame(8'h55, 1'b1);
    send_frame(8'hFF, 1'b1);
    gap(20);
    check("b2b_count", valid_cycs.size(), 2);
    if (valid_cycs.size() == 2)
      check("b2b_spacing", valid_cycs[1] - valid_cycs[0], 10 * C);
    check("data_ff", bus.rx_data, 8'hFF);

    for (int k = 0; k < 5 * C + 10; k++) begin
      bus.rxd = line_bit(8'h31, 1'b1, k / C);
      tick();
    end
    rst     = 1'b1;
    bus.rxd = 1'b1;
    repeat (3) tick();
    check("mid_rst_data", bus.rx_data, 8'h00);
    check("mid_rst_busy", bus.busy, 0);
    rst = 1'b0;
    gap(10);
    send_frame(8'h7E, 1'b1);
    gap(10);
    check("data_7e", bus.rx_data, 8'h7E);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        glitch($urandom_range(1, 10));
        gap($urandom_range(1, 10));
      end else begin
        automatic logic [7:0] d    = 8'($urandom);
        automatic logic       stop = ($urandom_range(0, 7) != 0);
        send_frame(d, stop);
        if (!stop) begin
          hold_and_release($urandom_range(0, 30));
          gap($urandom_range(5, 20));
        end else begin
          gap($urandom_range(0, 40));
        end
      end
    end

    gap(20);
    check("pending_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the lab UART: 8N1 frames, LSB first, line idles high.
- Synchronises the asynchronous rxd line and detects the start bit.
- Samples each bit at mid-period and presents the received byte with a one-cycle valid strobe.
- Sits in top_uart beside the transmitter; rx_data feeds the FND decode path.

Parameters:
- CLKS_PER_BIT, 23, clk cycles per bit period; must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer division, 11 at default), start-bit mid-sample offset; derived, do not override.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- rxd  input  1  asynchronous serial input, idle high
- rx_data  output  8  last good received byte; held until the next good frame
- rx_valid  output  1  one-cycle pulse: new byte on rx_data
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE, counters = 0.
  - rx_data = 8'h00, rx_valid = 0, frame_err = 0, busy = 0.
  - Both synchroniser flops = 1.
  - Reset mid-frame discards the partial byte; no pulse is generated.
- Synchroniser: rxd passes through two flops to give rxd_s (2-cycle delay). The FSM uses rxd_s only.
- Counter cnt: counts clk cycles within the current bit; reset to 0 on every state or bit transition.
- IDLE:
  - rxd_s == 0 -> START, cnt = 0.
  - Otherwise stay in IDLE.
- START:
  - At cnt == HALF_BIT-1, sample rxd_s.
  - Sample 0 -> DATA, bit_idx = 0, cnt = 0.
  - Sample 1 (glitch, false start) -> IDLE. No pulse is generated.
- DATA:
  - At cnt == CLKS_PER_BIT-1, shift rxd_s into the shift register LSB first (bit_idx 0 = bit 0).
  - Then cnt = 0 and bit_idx increments.
  - After bit_idx 7 is sampled -> STOP.
- STOP:
  - At cnt == CLKS_PER_BIT-1, sample rxd_s.
  - Sample 1 -> rx_data <= shift register; rx_valid = 1 for exactly the next cycle; -> IDLE.
  - Sample 0 -> frame_err = 1 for exactly the next cycle; rx_data is unchanged; -> WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rxd_s == 1, then -> IDLE.
  - A held-low line (break) therefore produces exactly one frame_err.
- Latency: rx_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the first clk edge at which rxd is low. That is 221 cycles at the default.
- Back-to-back frames:
  - IDLE is re-entered at the stop-bit mid-point.
  - A start edge arriving half a bit after the stop mid-point is accepted with no lost frame.
- rx_valid and frame_err are never high in the same cycle.
- busy is 0 in the cycle rx_valid is high.
- rx_data is never modified except on a good frame or by reset.

Test Plan:
- Reset, then hold rxd = 1 for 500 cycles -> busy = 0, rx_valid = 0, frame_err = 0, rx_data = 8'h00 throughout.
- Drive 0x31 with 23-cycle bits (start 0, bits 1,0,0,0,1,1,0,0, stop 1) -> single rx_valid pulse 221 cycles after the start edge, rx_data = 8'h31, frame_err = 0.
- Pulse rxd low for 5 cycles, then return high -> busy rises then returns to 0 after HALF_BIT cycles; no rx_valid, no frame_err.
- Frame 0xA5 with the stop bit driven 0, then the line held low for 100 cycles, then high:
  - exactly one frame_err pulse;
  - rx_data keeps its previous value 8'h31;
  - busy stays 1 until rxd_s returns high.
- Frames 0x55 then 0xFF, sent back-to-back with one stop bit each -> two rx_valid pulses 230 cycles apart, rx_data 8'h55 then 8'hFF.
- Assert rst during data bit 4 of a 0x31 frame, then release -> all outputs at reset values, no pulse; a following 0x7E frame is received correctly.
